// File: rtl/axi_sram_slave.sv
// AXI4 slave for the LSU data SRAM. The write (AW/W/B) and read (AR/R)
// channels run on independent FSMs. All outputs are registered.
module axi_sram_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned MEM_AW     = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic                  awvalid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic                  wvalid,
    input  logic                  wlast,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH+1)'(4 * MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    logic [31:0] mem [MEM_WORDS];

    wstate_t               wstate;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [7:0]            wlen;
    logic [7:0]            wcnt;
    logic [1:0]            wburst;
    logic                  werr;
    logic                  mem_we;

    rstate_t               rstate;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [7:0]            rlen;
    logic [7:0]            rcnt;
    logic [1:0]            rburst;
    logic                  rerr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_bad;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < MEM_BYTES;
    endfunction

    // Only 4-byte beats with FIXED or INCR bursts are supported.
    function automatic logic bad_attr(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || burst[1];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                        input logic [1:0] burst);
        return (burst == 2'b01) ? a + ADDR_WIDTH'(4) : a;
    endfunction

    // Commit a W beat; gated by rst_n so a beat coinciding with reset is dropped.
    always_comb begin
        mem_we = rst_n && (wstate == W_DATA) && wvalid && wready && !werr && in_range(waddr);
    end

    // SRAM write port.
    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr[MEM_AW+1:2]] <= wdata;
    end

    // Write FSM: accept AW, consume W beats, then return a single B response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= '0;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            wburst  <= '0;
            werr    <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    awready <= 1'b1;
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        waddr   <= awaddr;
                        wlen    <= awlen;
                        wburst  <= awburst;
                        werr    <= bad_attr(awsize, awburst);
                        wcnt    <= '0;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid && wready) begin
                        if (!in_range(waddr) || (wlast != (wcnt == wlen))) werr <= 1'b1;
                        if (wcnt == wlen) begin
                            wready <= 1'b0;
                            wstate <= W_RESP;
                        end else begin
                            wcnt  <= wcnt + 8'd1;
                            waddr <= next_addr(waddr, wburst);
                        end
                    end
                end
                W_RESP: begin
                    // First cycle in W_RESP raises bvalid with the final error status.
                    if (!bvalid) begin
                        bvalid <= 1'b1;
                        bresp  <= werr ? 2'b10 : 2'b00;
                    end else if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Address and error status of the beat to be loaded into the R registers.
    always_comb begin
        rd_addr = araddr;
        rd_bad  = bad_attr(arsize, arburst);
        if (rstate == R_DATA) begin
            rd_addr = next_addr(raddr, rburst);
            rd_bad  = rerr;
        end
        rd_bad = rd_bad || !in_range(rd_addr);
    end

    // Read FSM: beat 0 is loaded on the AR handshake, later beats on each R handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= '0;
            raddr   <= '0;
            rlen    <= '0;
            rcnt    <= '0;
            rburst  <= '0;
            rerr    <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    arready <= 1'b1;
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == 8'd0);
                        raddr   <= araddr;
                        rlen    <= arlen;
                        rburst  <= arburst;
                        rerr    <= bad_attr(arsize, arburst);
                        rcnt    <= '0;
                        rdata   <= rd_bad ? '0 : mem[rd_addr[MEM_AW+1:2]];
                        rresp   <= rd_bad ? 2'b10 : 2'b00;
                        rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid && rready) begin
                        if (rcnt == rlen) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            rcnt  <= rcnt + 8'd1;
                            raddr <= rd_addr;
                            rlast <= (rcnt + 8'd1 == rlen);
                            rdata <= rd_bad ? '0 : mem[rd_addr[MEM_AW+1:2]];
                            rresp <= rd_bad ? 2'b10 : 2'b00;
                        end
                    end
                end
            endcase
        end
    end

endmodule
